// File: rtl/tc_pl_cap_data_merge.sv
// Capture trigger responder and merged I/Q data source.
// A trigger latches a phase that selects one ADC channel pair. While running, every
// adc_valid sample of that pair is pushed into a 16-word first-word-fall-through FIFO
// that drains over a valid/ready handshake. A completion pulse flushes the FIFO and
// re-arms for the next trigger.
module tc_pl_cap_data_merge #(
    parameter int unsigned CAP0_3  = 2,
    parameter int unsigned ADC0_1  = 56,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [(2**CAP0_3)*ADC0_1-1:0]    adc_data,
    input  logic                             adc_valid,
    input  logic                             Gc_cap_trig,
    output logic                             Gc_capr_rdy,
    input  logic [CAP0_3-1:0]                Gc_cap_phase,
    input  logic                             Gc_cap_cmpt,
    output logic [ADC0_1-1:0]                Gc_merge_data,
    output logic                             Gc_mereg_datv,
    input  logic                             Gc_mereg_datr,
    output logic                             merge_ovf,
    output logic [31:0]                      merge_cnt
);

    localparam int unsigned NumPairs = 2 ** CAP0_3;
    localparam int unsigned Depth    = 2 ** FIFO_AW;

    localparam logic [FIFO_AW-1:0] PtrOne  = 1;
    localparam logic [FIFO_AW:0]   McntOne = 1;
    localparam logic [FIFO_AW+1:0] DepthL  = (FIFO_AW + 2)'(Depth);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e             state_q, state_d;
    logic               rdy_q, rdy_d;
    logic [CAP0_3-1:0]  phase_q, phase_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        cnt_q, cnt_d;

    // Storage behind the output register, plus the output register itself. The
    // occupancy seen by the producer is the sum of both, capped at Depth.
    logic [ADC0_1-1:0]  mem_q [Depth];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   mcnt_q;
    logic [ADC0_1-1:0]  out_data_q;
    logic               out_vld_q;

    logic [ADC0_1-1:0]  sel_word;
    logic [FIFO_AW+1:0] level;
    logic               full;
    logic               rd_xfer;
    logic               load;
    logic               wr_en;
    logic               flush;

    assign rd_xfer = out_vld_q & Gc_mereg_datr;
    // The output register refills from storage whenever it is empty or being drained.
    assign load    = (~out_vld_q | rd_xfer) & (mcnt_q != '0);
    assign level   = {1'b0, mcnt_q} + {{(FIFO_AW + 1){1'b0}}, out_vld_q};
    assign full    = (level >= DepthL);

    // Pick the {I,Q} word of the pair chosen by the latched phase.
    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < NumPairs; k++) begin
            if (phase_q == CAP0_3'(k)) begin
                sel_word = adc_data[k*ADC0_1 +: ADC0_1];
            end
        end
    end

    // Capture FSM: trigger acceptance, sample admission, overflow and count tracking.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Gc_cap_trig && rdy_q) begin
                    phase_d = Gc_cap_phase;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Completion wins over a coincident sample, which is not stored.
                if (Gc_cap_cmpt) begin
                    flush   = 1'b1;
                    state_d = StFlush;
                end else if (adc_valid) begin
                    // A read in the same cycle frees a slot even when full.
                    if (!full || rd_xfer) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 32'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Registered so that ready stays low through reset and rises one edge later.
        rdy_d = (state_d == StIdle);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rdy_q   <= 1'b0;
            phase_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= sel_word;
        end
    end

    // FIFO pointers, fill count and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mcnt_q     <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else if (flush) begin
            // Output data keeps its last value; only the queued words are discarded.
            wptr_q    <= '0;
            rptr_q    <= '0;
            mcnt_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (load) begin
                rptr_q <= rptr_q + PtrOne;
            end
            unique case ({wr_en, load})
                2'b10:   mcnt_q <= mcnt_q + McntOne;
                2'b01:   mcnt_q <= mcnt_q - McntOne;
                default: mcnt_q <= mcnt_q;
            endcase
            if (load) begin
                out_data_q <= mem_q[rptr_q];
                out_vld_q  <= 1'b1;
            end else if (rd_xfer) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign Gc_capr_rdy   = rdy_q;
    assign Gc_merge_data = out_data_q;
    assign Gc_mereg_datv = out_vld_q;
    assign merge_ovf     = ovf_q;
    assign merge_cnt     = cnt_q;

endmodule

// File: tb/tb_tc_pl_cap_data_merge.sv
// Self-checking bench for tc_pl_cap_data_merge: a vector table for the basic capture,
// directed sequences for overflow/flush/reset corners, and randomized traffic checked
// against a queue-based reference model.
module tb_tc_pl_cap_data_merge;

    localparam int CAP = 2;
    localparam int W   = 56;
    localparam int NP  = 4;
    localparam int DEP = 16;

    localparam logic [W-1:0] P0 = 56'hA0A0A0A0A0A0A0;
    localparam logic [W-1:0] P1 = 56'hB1B1B1B1B1B1B1;
    localparam logic [W-1:0] P2 = 56'h12345670ABCDEF;
    localparam logic [W-1:0] P3 = 56'hD3D3D3D3D3D3D3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*W-1:0] adc_data;
    logic            adc_valid;
    logic            trig;
    logic            rdy;
    logic [CAP-1:0]  cap_phase;
    logic            cmpt;
    logic [W-1:0]    mdata;
    logic            datv;
    logic            datr;
    logic            ovf;
    logic [31:0]     mcnt;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;

    tc_pl_cap_data_merge #(
        .CAP0_3 (CAP),
        .ADC0_1 (W),
        .FIFO_AW(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .Gc_cap_trig  (trig),
        .Gc_capr_rdy  (rdy),
        .Gc_cap_phase (cap_phase),
        .Gc_cap_cmpt  (cmpt),
        .Gc_merge_data(mdata),
        .Gc_mereg_datv(datv),
        .Gc_mereg_datr(datr),
        .merge_ovf    (ovf),
        .merge_cnt    (mcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue of {word, write edge}. A word can be
    // presented once a full edge has passed since it was written and it is at the head.
    typedef struct {
        logic [W-1:0] w;
        int           stamp;
    } ent_t;

    ent_t           mq[$];
    int             m_mode;   // 0 idle, 1 run, 2 flush
    logic [CAP-1:0] m_phase;
    logic           m_rdy;
    logic           m_ovf;
    logic [31:0]    m_cnt;
    logic [W-1:0]   m_last;
    int             edges;

    function automatic void model_reset();
        mq.delete();
        m_mode  = 0;
        m_phase = '0;
        m_rdy   = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
        m_last  = '0;
        edges   = 0;
    endfunction

    function automatic logic m_vis();
        return (mq.size() > 0) && (mq[0].stamp + 2 <= edges);
    endfunction

    function automatic void model_step();
        logic xfer;
        ent_t e;
        xfer = m_vis() && datr;
        case (m_mode)
            0: begin
                if (trig && m_rdy) begin
                    m_phase = cap_phase;
                    m_ovf   = 1'b0;
                    m_cnt   = '0;
                    m_mode  = 1;
                end
            end
            1: begin
                if (cmpt) begin
                    mq.delete();
                    m_mode = 2;
                end else begin
                    if (xfer) void'(mq.pop_front());
                    if (adc_valid) begin
                        if (mq.size() < DEP) begin
                            e.w     = W'(adc_data >> (int'(m_phase) * W));
                            e.stamp = edges;
                            mq.push_back(e);
                            m_cnt = m_cnt + 32'd1;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                end
            end
            default: m_mode = 0;
        endcase
        m_rdy = (m_mode == 0);
        edges++;
        if (m_vis()) m_last = mq[0].w;
    endfunction

    task automatic model_check();
        check("rdy", rdy, m_rdy);
        check("datv", datv, m_vis());
        check("data", mdata, m_last);
        check("ovf", ovf, m_ovf);
        check("cnt", mcnt, m_cnt);
    endtask

    // One clock: inputs are already stable; model advances on the edge, DUT is
    // sampled on the following falling edge.
    task automatic tick(input bit cmp_model);
        if (datv === 1'b1 && datr) n_xfer++;
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        if (cmp_model) model_check();
    endtask

    task automatic rand_data();
        for (int k = 0; k < NP * W / 32; k++) begin
            adc_data[k*32 +: 32] = $urandom();
        end
    endtask

    typedef struct {
        bit             trig;
        logic [CAP-1:0] ph;
        bit             vld;
        bit             datr;
        bit             e_rdy;
        bit             e_datv;
        logic [31:0]    e_cnt;
    } vec_t;

    vec_t tv[10];

    initial begin
        tv[0] = '{trig: 1'b0, ph: 2'd0, vld: 1'b0, datr: 1'b1, e_rdy: 1'b1, e_datv: 1'b0, e_cnt: 0};
        tv[1] = '{trig: 1'b1, ph: 2'd2, vld: 1'b0, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b0, e_cnt: 0};
        tv[2] = '{trig: 1'b0, ph: 2'd0, vld: 1'b1, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b0, e_cnt: 1};
        tv[3] = '{trig: 1'b0, ph: 2'd0, vld: 1'b1, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b1, e_cnt: 2};
        tv[4] = '{trig: 1'b0, ph: 2'd0, vld: 1'b1, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b1, e_cnt: 3};
        tv[5] = '{trig: 1'b0, ph: 2'd0, vld: 1'b1, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b1, e_cnt: 4};
        tv[6] = '{trig: 1'b0, ph: 2'd0, vld: 1'b1, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b1, e_cnt: 5};
        tv[7] = '{trig: 1'b0, ph: 2'd0, vld: 1'b0, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b1, e_cnt: 5};
        tv[8] = '{trig: 1'b0, ph: 2'd0, vld: 1'b0, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b0, e_cnt: 5};
        tv[9] = '{trig: 1'b0, ph: 2'd0, vld: 1'b0, datr: 1'b1, e_rdy: 1'b0, e_datv: 1'b0, e_cnt: 5};

        adc_data  = '0;
        adc_valid = 1'b0;
        trig      = 1'b0;
        cap_phase = '0;
        cmpt      = 1'b0;
        datr      = 1'b0;
        model_reset();

        // Reset values while reset is held
        #1 rst = 1'b0;
        #2;
        check("reset_rdy", rdy, 1'b0);
        check("reset_datv", datv, 1'b0);
        check("reset_data", mdata, '0);
        check("reset_ovf", ovf, 1'b0);
        check("reset_cnt", mcnt, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rdy_low_before_first_edge", rdy, 1'b0);

        // Basic capture on pair 2, table driven
        adc_data = {P3, P2, P1, P0};
        n_xfer   = 0;
        foreach (tv[i]) begin
            trig      = tv[i].trig;
            cap_phase = tv[i].ph;
            adc_valid = tv[i].vld;
            datr      = tv[i].datr;
            tick(1'b0);
            check($sformatf("tv%0d_rdy", i), rdy, tv[i].e_rdy);
            check($sformatf("tv%0d_datv", i), datv, tv[i].e_datv);
            check($sformatf("tv%0d_cnt", i), mcnt, tv[i].e_cnt);
            check($sformatf("tv%0d_ovf", i), ovf, 1'b0);
            if (tv[i].e_datv) check($sformatf("tv%0d_data", i), mdata, P2);
        end
        check("tv_xfers", n_xfer, 5);

        // Overflow with consumer stalled, then drain in order
        cmpt = 1'b1; tick(1'b1);
        cmpt = 1'b0; tick(1'b1);
        trig = 1'b1; cap_phase = 2'd1; tick(1'b1);
        trig = 1'b0; datr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            adc_valid = 1'b1;
            rand_data();
            tick(1'b1);
        end
        adc_valid = 1'b0;
        check("ovf_cnt16", mcnt, 16);
        check("ovf_set", ovf, 1'b1);
        datr   = 1'b1;
        n_xfer = 0;
        for (int i = 0; i < 40; i++) tick(1'b1);
        check("drain_xfers16", n_xfer, 16);
        check("drain_empty", datv, 1'b0);

        // Full FIFO with simultaneous read and write: no drop
        cmpt = 1'b1; tick(1'b1);
        cmpt = 1'b0; tick(1'b1);
        trig = 1'b1; cap_phase = 2'd0; tick(1'b1);
        trig = 1'b0; datr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            adc_valid = 1'b1;
            rand_data();
            tick(1'b1);
        end
        check("fill_cnt16", mcnt, 16);
        check("fill_no_ovf", ovf, 1'b0);
        datr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            tick(1'b1);
        end
        check("rw_full_no_ovf", ovf, 1'b0);
        check("rw_full_cnt26", mcnt, 26);
        datr = 1'b0;
        rand_data();
        tick(1'b1);
        check("still_full_drop", ovf, 1'b1);
        check("still_full_cnt", mcnt, 26);

        // Completion with 7 words queued and a coincident sample
        adc_valid = 1'b0; datr = 1'b1;
        for (int i = 0; i < 9; i++) tick(1'b1);
        datr = 1'b0; adc_valid = 1'b1; cmpt = 1'b1;
        tick(1'b1);
        check("cmpt_datv0", datv, 1'b0);
        check("cmpt_rdy0", rdy, 1'b0);
        check("cmpt_sample_not_written", mcnt, 26);
        adc_valid = 1'b0; cmpt = 1'b0;
        tick(1'b1);
        check("flush_rdy1", rdy, 1'b1);
        adc_data = {P3, P2, P1, P0};
        trig = 1'b1; cap_phase = 2'd2; tick(1'b1);
        check("retrig_ovf_clr", ovf, 1'b0);
        check("retrig_cnt_clr", mcnt, 0);
        trig = 1'b0; tick(1'b1);
        check("discarded", datv, 1'b0);

        // Trigger during run is ignored; completion in idle is ignored
        trig = 1'b1; cap_phase = 2'd3; adc_valid = 1'b1; tick(1'b1);
        trig = 1'b0; adc_valid = 1'b0; datr = 1'b1; tick(1'b1);
        check("run_trig_datv", datv, 1'b1);
        check("run_trig_pair", mdata, P2);
        tick(1'b1);
        cmpt = 1'b1; tick(1'b1);
        cmpt = 1'b0; tick(1'b1);
        cmpt = 1'b1; tick(1'b1);
        check("idle_cmpt_rdy", rdy, 1'b1);
        cmpt = 1'b0;
        trig = 1'b1; cap_phase = 2'd1; tick(1'b1);
        trig = 1'b0;
        check("idle_cmpt_then_trig", rdy, 1'b0);

        // Asynchronous reset mid-capture
        datr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1;
            rand_data();
            tick(1'b1);
        end
        adc_valid = 1'b0;
        tick(1'b1);
        check("pre_rst_datv", datv, 1'b1);
        check("pre_rst_cnt", mcnt, 4);
        #2 rst = 1'b0;
        #1;
        check("async_rst_rdy", rdy, 1'b0);
        check("async_rst_datv", datv, 1'b0);
        check("async_rst_data", mdata, '0);
        check("async_rst_ovf", ovf, 1'b0);
        check("async_rst_cnt", mcnt, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        datr = 1'b1;
        tick(1'b1);
        check("post_rst_rdy", rdy, 1'b1);
        check("post_rst_empty", datv, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit slow;
            slow      = ((i / 150) % 2) == 1;
            trig      = ($urandom_range(0, 3) == 0);
            cap_phase = CAP'($urandom_range(0, NP - 1));
            adc_valid = ($urandom_range(0, 2) != 0);
            datr      = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cmpt      = ($urandom_range(0, 59) == 0);
            rand_data();
            tick(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_pl_cap_data_merge.md
Name: tc_pl_cap_data_merge

Overview:
- Source/responder side of the capture trigger and merged-data interface.
- Accepts a capture trigger and phase from the capture controller, selects the ADC channel pair for that phase, and packs I/Q samples into ADC0_1-bit merged words.
- Streams the words over a valid/ready handshake until the consumer signals capture complete, then flushes and re-arms.
- Sits between the ADC sample front-end and the capture buffer logic.

Parameters:
- CAP0_3, 2: phase field width; 2**CAP0_3 channel pairs.
- ADC0_1, 56: merged word width; I and Q each ADC0_1/2 bits.
- FIFO_AW, 4: output FIFO address width; depth 2**FIFO_AW = 16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- adc_data  in  (2**CAP0_3)*ADC0_1  channel pairs; pair k occupies bits [k*ADC0_1 +: ADC0_1], with I in the upper half and Q in the lower half.
- adc_valid  in  1  all pairs carry a new sample this cycle.
- Gc_cap_trig  in  1  capture trigger pulse.
- Gc_capr_rdy  out  1  ready to accept a trigger.
- Gc_cap_phase  in  CAP0_3  phase/pair select; sampled when the trigger is accepted.
- Gc_cap_cmpt  in  1  consumer has taken all points (pulse).
- Gc_merge_data  out  ADC0_1  merged word, {I,Q} of the selected pair.
- Gc_mereg_datv  out  1  merged word valid.
- Gc_mereg_datr  in  1  consumer ready.
- merge_ovf  out  1  sticky overflow flag; a sample was dropped.
- merge_cnt  out  32  words written into the FIFO in the current capture.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE, FIFO empty, phase register 0.
  - Gc_capr_rdy=0 during reset, and 1 from the first clock edge after release.
  - Gc_mereg_datv=0, Gc_merge_data=0, merge_ovf=0, merge_cnt=0.
  - Reset mid-capture aborts immediately and discards FIFO contents.
- States:
  - IDLE:
    - Gc_capr_rdy=1.
    - Trigger accepted when Gc_cap_trig=1 and Gc_capr_rdy=1. On acceptance: latch Gc_cap_phase, clear merge_ovf and merge_cnt, go to RUN.
    - Gc_cap_cmpt is ignored in IDLE.
    - adc_valid is ignored in IDLE; no write.
  - RUN:
    - Gc_capr_rdy=0; Gc_cap_trig is ignored.
    - Each adc_valid cycle writes the latched pair's word into the FIFO, and merge_cnt increments by 1 (wraps at 2**32).
    - On Gc_cap_cmpt=1, go to FLUSH. An adc_valid in the same cycle as cmpt is NOT written.
  - FLUSH:
    - Lasts exactly one cycle: FIFO pointers reset, datv=0, then go to IDLE.
    - Gc_capr_rdy returns high 2 cycles after the cmpt cycle.
- FIFO:
  - First-word-fall-through.
  - A word written at edge N gives Gc_mereg_datv=1 after edge N+1 (1-cycle latency) if the FIFO was empty.
- Handshake:
  - Transfer occurs on an edge where datv=1 and datr=1.
  - When datr=0, Gc_merge_data and datv hold stable.
  - datv never deasserts without a transfer, except on entry to FLUSH or on reset.
- Simultaneous read and write:
  - Allowed in the same cycle, including when the FIFO is full.
  - A full FIFO with a read in the same cycle accepts the write; no drop.
- Full (16 words, no read that cycle):
  - adc_valid sample is dropped, merge_cnt does not increment, merge_ovf is set (sticky until the next accepted trigger).
- Empty: datv=0, and Gc_merge_data holds its last value.
- Phase: the phase latched at trigger acceptance is used for the whole capture; later changes to Gc_cap_phase have no effect.

Test Plan:
- Reset, then trigger with phase=2; drive 5 adc_valid samples with pair2 = {28'h1234567, 28'h0ABCDEF}, datr=1 → 5 words of 56'h12345670ABCDEF, first datv one cycle after the first write, merge_cnt=5, merge_ovf=0.
- Hold datr=0 and drive 20 consecutive adc_valid → FIFO holds 16, merge_cnt=16, merge_ovf=1; release datr → exactly 16 words in write order.
- Fill the FIFO to 16, then assert datr and adc_valid together for 10 cycles → no drop, merge_ovf=0, level stays 16.
- Gc_cap_cmpt with 7 words queued and adc_valid=1 in the same cycle → datv=0 the next cycle, queued words discarded, rdy=1 two cycles after cmpt; a new trigger clears merge_ovf/merge_cnt.
- Gc_cap_trig during RUN with phase=3 → ignored; output stays on the original pair. Gc_cap_cmpt in IDLE → no state change.
- Assert rst=0 mid-RUN with 4 words queued → all outputs return to reset values asynchronously; after release, rdy=1 and the FIFO is empty.
